// File: rtl/link_tx_sequencer_if.sv
// Bit-stream handshake bundle between frame packer, link sequencer and Manchester encoder.
interface link_tx_sequencer_if;
  logic pk_bit;
  logic pk_valid;
  logic pk_sof;
  logic pk_ready;
  logic enc_bit;
  logic enc_valid;
  logic enc_ready;

  // master: the sequencer (sinks packer bits, sources encoder bits)
  modport master (
    input  pk_bit, pk_valid, pk_sof, enc_ready,
    output pk_ready, enc_bit, enc_valid
  );

  // slave: the surrounding packer/encoder pair
  modport slave (
    output pk_bit, pk_valid, pk_sof, enc_ready,
    input  pk_ready, enc_bit, enc_valid
  );
endinterface

// File: rtl/link_tx_sequencer.sv
// Link bring-up sequencer: training preamble, sync words, SPI arm, frame passthrough,
// periodic resync insertion and frame-aligned teardown onto the encoder bit input.
module link_tx_sequencer #(
  parameter int unsigned       TRAIN_BITS    = 64,
  parameter int unsigned       SYNC_W        = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD     = 16'hF0A5,
  parameter int unsigned       FRAME_BITS    = 40,
  parameter int unsigned       ARM_TIMEOUT   = 65535,
  parameter int unsigned       RESYNC_FRAMES = 256
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       err_clr,
  link_tx_sequencer_if.master        lnk,
  output logic                       spi_enable,
  output logic [2:0]                 state_o,
  output logic [15:0]                frame_cnt,
  output logic                       underrun,
  output logic                       framing_err,
  output logic                       arm_timeout
);

  localparam int unsigned IW  = $clog2((TRAIN_BITS > SYNC_W) ? TRAIN_BITS : SYNC_W) + 1;
  localparam int unsigned SIW = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;
  localparam int unsigned FW  = $clog2(FRAME_BITS + 1);
  localparam int unsigned RW  = $clog2(RESYNC_FRAMES + 2);
  localparam int unsigned AW  = $clog2(ARM_TIMEOUT + 1);

  localparam logic [IW-1:0] TB_LAST = IW'(TRAIN_BITS - 1);
  localparam logic [IW-1:0] SW_LAST = IW'(SYNC_W - 1);
  localparam logic [FW-1:0] FB_L    = FW'(FRAME_BITS);
  localparam logic [RW-1:0] RS_L    = RW'(RESYNC_FRAMES);
  localparam logic [AW-1:0] AT_L    = AW'(ARM_TIMEOUT);
  localparam logic [AW-1:0] AT_LAST = AW'(ARM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRAIN = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_SYNC  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t          r_state, w_state_nx;
  logic [IW-1:0]   r_idx, w_idx_nx;
  logic [FW-1:0]   r_fcnt, w_fcnt_nx;
  logic [RW-1:0]   r_done, w_done_nx;
  logic [AW-1:0]   r_arm_cyc;
  logic            r_gen_bit, r_gen_valid, w_gen_bit_nx, w_gen_valid_nx;
  logic [15:0]     r_frame_cnt;
  logic            r_underrun, r_framing_err, r_arm_timeout;
  logic [SYNC_W-1:0] w_sync_rev;
  logic            w_pass, w_gen_xfer, w_pk_xfer, w_sof_xfer, w_mid, w_frame_end;
  logic            w_set_under, w_set_frm, w_set_arm;

  // Reversed so that generator index 0 selects the MSB of the sync word.
  assign w_sync_rev = {<<{SYNC_WORD}};

  assign w_pass     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_gen_xfer = r_gen_valid & lnk.enc_ready;
  assign w_pk_xfer  = w_pass & lnk.pk_valid & lnk.enc_ready;
  assign w_sof_xfer = w_pk_xfer & lnk.pk_sof;
  assign w_mid      = (r_fcnt != '0) && (r_fcnt < FB_L);

  assign lnk.enc_bit   = w_pass ? lnk.pk_bit   : r_gen_bit;
  assign lnk.enc_valid = w_pass ? lnk.pk_valid : r_gen_valid;

  always_comb begin
    lnk.pk_ready = 1'b0;
    case (r_state)
      S_RUN, S_DRAIN: lnk.pk_ready = lnk.enc_ready;
      S_ARM:          lnk.pk_ready = ~lnk.pk_sof;
      default:        lnk.pk_ready = 1'b0;
    endcase
  end

  assign spi_enable  = (r_state == S_ARM) || (r_state == S_RUN) || (r_state == S_SYNC);
  assign state_o     = r_state;
  assign frame_cnt   = r_frame_cnt;
  assign underrun    = r_underrun;
  assign framing_err = r_framing_err;
  assign arm_timeout = r_arm_timeout;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_fcnt_nx  = r_fcnt;
    w_done_nx  = r_done;
    if (w_pk_xfer) begin
      if (lnk.pk_sof)  w_fcnt_nx = FW'(1);
      else if (w_mid)  w_fcnt_nx = r_fcnt + 1'b1;
    end
    w_frame_end = w_pk_xfer && (w_fcnt_nx == FB_L);
    unique case (r_state)
      S_IDLE: begin
        w_done_nx = '0;
        w_fcnt_nx = '0;
        if (enable) begin
          w_state_nx = S_TRAIN;
          w_idx_nx   = '0;
        end
      end
      S_TRAIN: if (w_gen_xfer) begin
        if (!enable) w_state_nx = S_IDLE;
        else if (r_idx == TB_LAST) begin
          w_state_nx = S_ARM;
          w_idx_nx   = '0;
        end else w_idx_nx = r_idx + 1'b1;
      end
      S_ARM, S_SYNC: if (w_gen_xfer) begin
        if (!enable) w_state_nx = S_IDLE;
        else if (r_idx == SW_LAST) begin
          w_idx_nx = '0;
          if ((r_state == S_SYNC) || (lnk.pk_valid && lnk.pk_sof)) begin
            w_state_nx = S_RUN;
            w_fcnt_nx  = '0;
          end
        end else w_idx_nx = r_idx + 1'b1;
      end
      S_RUN, S_DRAIN: begin
        // Frame end takes priority so a drop of enable on the last bit goes straight to IDLE.
        if (w_frame_end) begin
          w_done_nx = r_done + 1'b1;
          if (!enable || (r_state == S_DRAIN)) w_state_nx = S_IDLE;
          else if ((RESYNC_FRAMES != 0) && (w_done_nx == RS_L)) begin
            w_state_nx = S_SYNC;
            w_done_nx  = '0;
            w_idx_nx   = '0;
          end
        end else if (!enable && (r_state == S_RUN)) begin
          w_state_nx = ((w_fcnt_nx != '0) && (w_fcnt_nx < FB_L)) ? S_DRAIN : S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_gen_valid_nx = 1'b0;
    w_gen_bit_nx   = 1'b0;
    case (w_state_nx)
      S_TRAIN: begin
        w_gen_valid_nx = 1'b1;
        w_gen_bit_nx   = ~w_idx_nx[0];
      end
      S_ARM, S_SYNC: begin
        w_gen_valid_nx = 1'b1;
        w_gen_bit_nx   = w_sync_rev[w_idx_nx[SIW-1:0]];
      end
      default: ;
    endcase
  end

  assign w_set_under = w_pass & ~lnk.pk_valid & lnk.enc_ready & w_mid;
  assign w_set_frm   = w_sof_xfer & w_mid;
  assign w_set_arm   = (r_state == S_ARM) && (r_arm_cyc == AT_LAST);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_fcnt        <= '0;
      r_done        <= '0;
      r_arm_cyc     <= '0;
      r_gen_bit     <= 1'b0;
      r_gen_valid   <= 1'b0;
      r_frame_cnt   <= '0;
      r_underrun    <= 1'b0;
      r_framing_err <= 1'b0;
      r_arm_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_fcnt      <= w_fcnt_nx;
      r_done      <= w_done_nx;
      r_gen_bit   <= w_gen_bit_nx;
      r_gen_valid <= w_gen_valid_nx;
      if (r_state != S_ARM)      r_arm_cyc <= '0;
      else if (r_arm_cyc != AT_L) r_arm_cyc <= r_arm_cyc + 1'b1;
      if (w_sof_xfer) r_frame_cnt <= r_frame_cnt + 1'b1;
      r_underrun    <= w_set_under | (r_underrun    & ~err_clr);
      r_framing_err <= w_set_frm   | (r_framing_err & ~err_clr);
      r_arm_timeout <= w_set_arm   | (r_arm_timeout & ~err_clr);
    end
  end

endmodule

// File: doc/link_tx_sequencer.md
Name: link_tx_sequencer

Overview:
- Sequences and shares the Manchester encoder bit input between two sources: the frame packer's data bit stream and an internal training/sync pattern generator.
- Runs link bring-up in order: training preamble, then sync words, then SPI capture enable, then data passthrough.
- Inserts periodic resync words between frames and tears the link down cleanly on a frame boundary.
- Sits in the clk_sys domain between frame_packer_100m and manchester_encoder_ddr, and drives the SPI master enable.

Parameters:
- TRAIN_BITS, 64: alternating-pattern preamble length in bits. Minimum 2, must be even.
- SYNC_W, 16: sync word width.
- SYNC_WORD, 16'hF0A5: sync pattern, sent MSB first.
- FRAME_BITS, 40: bits per packer frame, counted from the SOF bit inclusive.
- ARM_TIMEOUT, 65535: clk_sys cycles allowed in ARM before the timeout flag sets.
- RESYNC_FRAMES, 256: completed frames between inserted sync words. 0 disables insertion.

Ports:
- clk_sys  in  1  100MHz system clock.
- rst_n  in  1  Asynchronous active-low reset.
- enable  in  1  Link enable request.
- err_clr  in  1  Single-cycle pulse; clears all sticky flags.
- pk_bit  in  1  Packer data bit.
- pk_valid  in  1  Packer bit valid.
- pk_sof  in  1  Qualifies pk_bit as the first bit of a frame.
- pk_ready  out  1  Ready to packer.
- enc_bit  out  1  Bit to encoder.
- enc_valid  out  1  Valid to encoder.
- enc_ready  in  1  Encoder ready.
- spi_enable  out  1  Enable to SPI master.
- state_o  out  3  Current state: IDLE=0, TRAIN=1, ARM=2, RUN=3, SYNC=4, DRAIN=5.
- frame_cnt  out  16  Frames started in RUN/DRAIN; wraps at 65535 to 0.
- underrun  out  1  Sticky flag.
- framing_err  out  1  Sticky flag.
- arm_timeout  out  1  Sticky flag.

Behaviour:
- Reset: state IDLE. pk_ready=0, enc_valid=0, enc_bit=0, spi_enable=0, frame_cnt=0, all sticky flags 0, all counters 0.
- Handshake: a bit transfers on enc_valid & enc_ready. enc_bit/enc_valid hold stable while enc_valid=1 and enc_ready=0.
- Bit counting: every counter below advances only on a transfer.
- IDLE:
  - enc_valid=0, pk_ready=0, spi_enable=0.
  - enable=1 sampled → TRAIN on the next cycle.
- TRAIN:
  - Generator drives 1,0,1,0,… with enc_valid=1.
  - After TRAIN_BITS transfers → ARM.
- ARM:
  - spi_enable=1. Generator sends SYNC_WORD repeatedly.
  - Cycle counter runs from ARM entry. Reaching ARM_TIMEOUT sets arm_timeout; state is unchanged.
  - At a sync-word boundary with pk_valid=1 & pk_sof=1 → RUN.
  - Non-SOF bits offered by the packer are consumed and discarded: pk_ready=1 only when pk_sof=0.
- RUN (combinational passthrough):
  - enc_bit=pk_bit, enc_valid=pk_valid, pk_ready=enc_ready.
  - Frame bit counter is set to 1 on an SOF transfer and increments per transfer.
  - frame_cnt increments on each SOF transfer.
  - pk_valid=0 while enc_ready=1 and the counter is in 1..FRAME_BITS-1 sets underrun.
  - SOF transfer with the counter in 1..FRAME_BITS-1 sets framing_err and restarts the count at 1.
  - At frame end (counter reaches FRAME_BITS):
    - enable=0 → IDLE.
    - else completed-frame count equals RESYNC_FRAMES (nonzero) → SYNC; clear the completed-frame count.
- SYNC:
  - pk_ready=0. Generator sends one SYNC_WORD.
  - After SYNC_W transfers → RUN, awaiting the next SOF.
- enable deasserted:
  - In TRAIN, ARM or SYNC: finish the in-flight bit (if enc_valid=1 and not yet accepted), then IDLE.
  - In RUN mid-frame: → DRAIN. DRAIN is passthrough as in RUN until frame end, then IDLE.
  - In RUN between frames (counter 0 or FRAME_BITS): → IDLE directly.
  - spi_enable deasserts on entry to DRAIN or IDLE.
- enable reasserted in DRAIN: ignored. The link completes the frame, returns to IDLE, then restarts with TRAIN.
- Sticky flags: err_clr clears them. If err_clr and a set event occur in the same cycle, set wins.
- Async reset mid-operation: returns to the reset values immediately. No partial-frame flush.
- Latency: passthrough is 0 cycles. Generator bits are registered, 1 cycle from the state decision.

Test Plan:
- Reset, enable=1, enc_ready=1 → exactly 64 alternating bits starting with 1, then 0xF0A5 MSB first; spi_enable rises on the first sync bit.
- In ARM, present pk_sof with a 40-bit frame at a word boundary → RUN, frame bits pass bit-exact to enc_bit, frame_cnt=1.
- RESYNC_FRAMES=2, stream 4 frames → one SYNC_WORD after frame 2 and after frame 4, pk_ready=0 during each; frame_cnt=4.
- Drop enable at bit 20 of a frame → remaining 20 bits transmitted, then IDLE, enc_valid=0, spi_enable=0.
- pk_valid low 3 cycles at bit 10 → underrun=1. pk_sof at bit 15 → framing_err=1. err_clr → both 0.
- ARM_TIMEOUT=100, no packer data → arm_timeout=1 at cycle 100, sync words continue; enc_ready toggling holds enc_bit stable.
